// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared TLB entry layout, page-size and INVTLB op constants
package tlb_pkg;

  localparam int TLB_ENTRY_W = 89;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd21;

  localparam logic [4:0] INV_ALL0       = 5'd0;
  localparam logic [4:0] INV_ALL1       = 5'd1;
  localparam logic [4:0] INV_G          = 5'd2;
  localparam logic [4:0] INV_NG         = 5'd3;
  localparam logic [4:0] INV_NG_ASID    = 5'd4;
  localparam logic [4:0] INV_NG_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GA_VA      = 5'd6;

  // One page's attributes: ppn 25:6, plv 5:4, mat 3:2, d 1, v 0
  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } tlb_page_t;

  // e 88, vppn 87:69, ps 68:63, asid 62:53, g 52, page0 51:26, page1 25:0
  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    tlb_page_t   p0;
    tlb_page_t   p1;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_match.sv
// rtl/tlb_match.sv - single-entry VA and ASID comparator
module tlb_match
  import tlb_pkg::*;
(
  input  logic [18:0] e_vppn,
  input  logic [5:0]  e_ps,
  input  logic [9:0]  e_asid,
  input  logic [18:0] q_vppn,
  input  logic [9:0]  q_asid,
  output logic        va_match,
  output logic        asid_match
);

  // 4M pages ignore the low nine VPPN bits
  always_comb begin
    va_match   = (e_vppn[18:9] == q_vppn[18:9]) &&
                 ((e_ps == PS_4M) || (e_vppn[8:0] == q_vppn[8:0]));
    asid_match = (e_asid == q_asid);
  end

endmodule

// File: rtl/tlb_mp.sv
// rtl/tlb_mp.sv - multi-port TLB with fill-index generator and INVTLB
module tlb_mp
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 16,
  parameter  int NPORTS = 2,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        s_req,
  input  logic [NPORTS*19-1:0]     s_vppn,
  input  logic [NPORTS-1:0]        s_va_bit12,
  input  logic [NPORTS*10-1:0]     s_asid,
  output logic [NPORTS-1:0]        s_rvalid,
  output logic [NPORTS-1:0]        s_found,
  output logic [NPORTS*IDXW-1:0]   s_index,
  output logic [NPORTS*20-1:0]     s_ppn,
  output logic [NPORTS*6-1:0]      s_ps,
  output logic [NPORTS*2-1:0]      s_plv,
  output logic [NPORTS*2-1:0]      s_mat,
  output logic [NPORTS-1:0]        s_d,
  output logic [NPORTS-1:0]        s_v,
  input  logic                     we,
  input  logic                     w_fill,
  input  logic [IDXW-1:0]          w_index,
  input  logic [TLB_ENTRY_W-1:0]   w_entry,
  output logic [IDXW-1:0]          fill_index,
  input  logic                     r_req,
  input  logic [IDXW-1:0]          r_index,
  output logic [TLB_ENTRY_W-1:0]   r_entry,
  input  logic                     inv_valid,
  input  logic [4:0]               inv_op,
  input  logic [9:0]               inv_asid,
  input  logic [18:0]              inv_vppn,
  output logic                     inv_err
);

  tlb_entry_t               mem [TLBNUM];
  logic [IDXW-1:0]          rr_ptr;
  logic [NPORTS*TLBNUM-1:0] s_va_m, s_asid_m;
  logic [TLBNUM-1:0]        inv_va_m, inv_asid_m, inv_clr;
  logic [NPORTS-1:0]        hit_any;
  logic [IDXW-1:0]          hit_idx [NPORTS];
  logic [5:0]               sel_ps  [NPORTS];
  tlb_page_t                sel_pg  [NPORTS];
  logic                     any_free;
  logic [IDXW-1:0]          free_idx, w_idx;

  for (genvar i = 0; i < TLBNUM; i++) begin : g_ent
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
      tlb_match u_s_match (
        .e_vppn     (mem[i].vppn),
        .e_ps       (mem[i].ps),
        .e_asid     (mem[i].asid),
        .q_vppn     (s_vppn[p*19 +: 19]),
        .q_asid     (s_asid[p*10 +: 10]),
        .va_match   (s_va_m[p*TLBNUM + i]),
        .asid_match (s_asid_m[p*TLBNUM + i])
      );
    end
    tlb_match u_inv_match (
      .e_vppn     (mem[i].vppn),
      .e_ps       (mem[i].ps),
      .e_asid     (mem[i].asid),
      .q_vppn     (inv_vppn),
      .q_asid     (inv_asid),
      .va_match   (inv_va_m[i]),
      .asid_match (inv_asid_m[i])
    );
  end

  // Per-port priority hit (lowest index wins) and odd/even page select
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      hit_any[p] = 1'b0;
      hit_idx[p] = '0;
      sel_ps[p]  = '0;
      sel_pg[p]  = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (mem[i].e && (mem[i].g || s_asid_m[p*TLBNUM + i]) && s_va_m[p*TLBNUM + i]) begin
          hit_any[p] = 1'b1;
          hit_idx[p] = IDXW'(i);
        end
      end
      if (hit_any[p]) begin
        sel_ps[p] = mem[hit_idx[p]].ps;
        if ((mem[hit_idx[p]].ps == PS_4K) ? s_va_bit12[p] : s_vppn[p*19 + 8])
          sel_pg[p] = mem[hit_idx[p]].p1;
        else
          sel_pg[p] = mem[hit_idx[p]].p0;
      end
    end
  end

  // Fill prefers the lowest invalid slot, else the round-robin pointer
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (!mem[i].e) begin
        any_free = 1'b1;
        free_idx = IDXW'(i);
      end
    end
  end

  assign fill_index = any_free ? free_idx : rr_ptr;
  assign w_idx      = w_fill ? fill_index : w_index;

  // INVTLB selection per entry; unknown ops select nothing
  always_comb begin
    inv_clr = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      case (inv_op)
        INV_ALL0, INV_ALL1: inv_clr[i] = 1'b1;
        INV_G:              inv_clr[i] = mem[i].g;
        INV_NG:             inv_clr[i] = !mem[i].g;
        INV_NG_ASID:        inv_clr[i] = !mem[i].g && inv_asid_m[i];
        INV_NG_ASID_VA:     inv_clr[i] = !mem[i].g && inv_asid_m[i] && inv_va_m[i];
        INV_GA_VA:          inv_clr[i] = (mem[i].g || inv_asid_m[i]) && inv_va_m[i];
        default:            inv_clr[i] = 1'b0;
      endcase
    end
  end

  // Entry array, rr pointer, read port and error pulse; the write lands after INVTLB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) mem[i] <= '0;
      rr_ptr  <= '0;
      r_entry <= '0;
      inv_err <= 1'b0;
    end else begin
      inv_err <= inv_valid && (inv_op > INV_GA_VA);
      if (inv_valid) begin
        for (int i = 0; i < TLBNUM; i++)
          if (inv_clr[i]) mem[i].e <= 1'b0;
      end
      if (we) mem[w_idx] <= w_entry;
      if (we && w_fill && !any_free) rr_ptr <= rr_ptr + 1'b1;
      if (r_req) r_entry <= mem[r_index];
    end
  end

  // Search result registers load only on request; valid is a one-cycle echo
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_rvalid <= '0;
      s_found  <= '0;
      s_index  <= '0;
      s_ppn    <= '0;
      s_ps     <= '0;
      s_plv    <= '0;
      s_mat    <= '0;
      s_d      <= '0;
      s_v      <= '0;
    end else begin
      s_rvalid <= s_req;
      for (int p = 0; p < NPORTS; p++) begin
        if (s_req[p]) begin
          s_found[p]               <= hit_any[p];
          s_index[p*IDXW +: IDXW]  <= hit_idx[p];
          s_ppn[p*20 +: 20]        <= sel_pg[p].ppn;
          s_ps[p*6 +: 6]           <= sel_ps[p];
          s_plv[p*2 +: 2]          <= sel_pg[p].plv;
          s_mat[p*2 +: 2]          <= sel_pg[p].mat;
          s_d[p]                   <= sel_pg[p].d;
          s_v[p]                   <= sel_pg[p].v;
        end
      end
    end
  end

endmodule

// File: tb/tb_tlb_mp.sv
// tb/tb_tlb_mp.sv - directed and randomized checks of tlb_mp against a behavioural model
module tb_tlb_mp;
  import tlb_pkg::*;

  localparam int TLBNUM = 16;
  localparam int NPORTS = 2;
  localparam int IDXW   = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NPORTS-1:0]      s_req = '0;
  logic [NPORTS*19-1:0]   s_vppn = '0;
  logic [NPORTS-1:0]      s_va_bit12 = '0;
  logic [NPORTS*10-1:0]   s_asid = '0;
  logic [NPORTS-1:0]      s_rvalid, s_found, s_d, s_v;
  logic [NPORTS*IDXW-1:0] s_index;
  logic [NPORTS*20-1:0]   s_ppn;
  logic [NPORTS*6-1:0]    s_ps;
  logic [NPORTS*2-1:0]    s_plv, s_mat;
  logic                   we = 1'b0, w_fill = 1'b0;
  logic [IDXW-1:0]        w_index = '0;
  logic [TLB_ENTRY_W-1:0] w_entry = '0;
  logic [IDXW-1:0]        fill_index;
  logic                   r_req = 1'b0;
  logic [IDXW-1:0]        r_index = '0;
  logic [TLB_ENTRY_W-1:0] r_entry;
  logic                   inv_valid = 1'b0;
  logic [4:0]             inv_op = '0;
  logic [9:0]             inv_asid = '0;
  logic [18:0]            inv_vppn = '0;
  logic                   inv_err;

  tlb_mp #(.TLBNUM(TLBNUM), .NPORTS(NPORTS)) dut (
    .clk(clk), .reset(reset),
    .s_req(s_req), .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
    .s_rvalid(s_rvalid), .s_found(s_found), .s_index(s_index), .s_ppn(s_ppn),
    .s_ps(s_ps), .s_plv(s_plv), .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
    .we(we), .w_fill(w_fill), .w_index(w_index), .w_entry(w_entry),
    .fill_index(fill_index), .r_req(r_req), .r_index(r_index), .r_entry(r_entry),
    .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .inv_err(inv_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  tlb_entry_t ment [TLBNUM];
  int         rr;
  bit         e_rvalid [NPORTS];
  bit         e_found  [NPORTS];
  int         e_idx    [NPORTS];
  logic [5:0] e_ps     [NPORTS];
  tlb_page_t  e_pg     [NPORTS];
  tlb_entry_t e_rent;
  bit         e_inv_err;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_fill();
    for (int i = 0; i < TLBNUM; i++) if (!ment[i].e) return i;
    return rr;
  endfunction

  function automatic bit m_va(tlb_entry_t x, logic [18:0] v);
    if ((x.vppn >> 9) != (v >> 9)) return 1'b0;
    return (x.ps == 6'd21) || (x.vppn == v);
  endfunction

  function automatic bit m_inv(tlb_entry_t x, logic [4:0] op, logic [9:0] a, logic [18:0] v);
    bit am = (x.asid == a);
    bit vm = m_va(x, v);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2: return x.g;
      5'd3: return !x.g;
      5'd4: return !x.g && am;
      5'd5: return !x.g && am && vm;
      5'd6: return (x.g || am) && vm;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < TLBNUM; i++) ment[i] = '0;
    rr = 0;
    for (int p = 0; p < NPORTS; p++) begin
      e_rvalid[p] = 0; e_found[p] = 0; e_idx[p] = 0; e_ps[p] = '0; e_pg[p] = '0;
    end
    e_rent = '0;
    e_inv_err = 0;
  endtask

  // Applies one clock edge of architectural behaviour to the model
  task automatic m_step();
    logic [18:0] v;
    logic [9:0]  a;
    bit          full;
    int          fi;
    for (int p = 0; p < NPORTS; p++) begin
      e_rvalid[p] = s_req[p];
      if (s_req[p]) begin
        v = s_vppn[p*19 +: 19];
        a = s_asid[p*10 +: 10];
        e_found[p] = 0; e_idx[p] = 0; e_ps[p] = '0; e_pg[p] = '0;
        for (int i = 0; i < TLBNUM; i++) begin
          if (ment[i].e && (ment[i].g || ment[i].asid == a) && m_va(ment[i], v)) begin
            e_found[p] = 1;
            e_idx[p]   = i;
            e_ps[p]    = ment[i].ps;
            e_pg[p]    = ((ment[i].ps == 6'd12) ? s_va_bit12[p] : v[8]) ? ment[i].p1 : ment[i].p0;
            break;
          end
        end
      end
    end
    if (r_req) e_rent = ment[r_index];
    e_inv_err = inv_valid && (inv_op >= 5'd7);
    full = 1;
    for (int i = 0; i < TLBNUM; i++) if (!ment[i].e) full = 0;
    fi = m_fill();
    if (inv_valid)
      for (int i = 0; i < TLBNUM; i++)
        if (m_inv(ment[i], inv_op, inv_asid, inv_vppn)) ment[i].e = 1'b0;
    if (we) begin
      ment[w_fill ? fi : int'(w_index)] = w_entry;
      if (w_fill && full) rr = (rr + 1) % TLBNUM;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic idle();
    s_req = '0; we = 0; w_fill = 0; r_req = 0; inv_valid = 0;
  endtask

  function automatic tlb_entry_t mk(logic [18:0] vppn, logic [5:0] ps, logic [9:0] asid,
                                    logic g, logic [19:0] ppn0, logic [19:0] ppn1);
    tlb_entry_t x = '0;
    x.e = 1; x.vppn = vppn; x.ps = ps; x.asid = asid; x.g = g;
    x.p0.ppn = ppn0; x.p0.v = 1;
    x.p1.ppn = ppn1; x.p1.v = 1; x.p1.d = 1; x.p1.plv = 2'd3;
    return x;
  endfunction

  function automatic logic [18:0] rnd_vppn();
    return 19'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 1) << 8) | $urandom_range(0, 3));
  endfunction

  function automatic tlb_entry_t rnd_entry();
    tlb_entry_t x;
    x      = 89'({$urandom, $urandom, $urandom});
    x.e    = ($urandom_range(0, 7) != 0);
    x.vppn = rnd_vppn();
    x.ps   = ($urandom_range(0, 1) != 0) ? PS_4M : PS_4K;
    x.asid = 10'($urandom_range(0, 3));
    return x;
  endfunction

  // Every cycle: DUT outputs against the model
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("fill_index", fill_index, m_fill());
      chk("inv_err", inv_err, e_inv_err);
      chk("r_entry", r_entry, e_rent);
      for (int p = 0; p < NPORTS; p++) begin
        chk("s_rvalid", s_rvalid[p], e_rvalid[p]);
        chk("s_found", s_found[p], e_found[p]);
        chk("s_index", s_index[p*IDXW +: IDXW], e_idx[p]);
        chk("s_ppn", s_ppn[p*20 +: 20], e_pg[p].ppn);
        chk("s_ps", s_ps[p*6 +: 6], e_ps[p]);
        chk("s_plv", s_plv[p*2 +: 2], e_pg[p].plv);
        chk("s_mat", s_mat[p*2 +: 2], e_pg[p].mat);
        chk("s_d_v", {s_d[p], s_v[p]}, {e_pg[p].d, e_pg[p].v});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_reset();
    #12;
    reset  = 0;
    cmp_en = 1;

    // Reset state and miss on an empty TLB
    idle();
    s_req = 2'b11; s_vppn = 38'h12345_6789; s_asid = 20'h3_2211;
    chk("reset_fill_index", fill_index, 0);
    tick();
    chk("empty_rvalid", s_rvalid, 2'b11);
    chk("empty_found", s_found, 2'b00);

    // 4K global-off entry into slot 0
    idle();
    we = 1; w_fill = 1; w_entry = mk(19'h00100, PS_4K, 10'd5, 1'b0, 20'h1A, 20'h1B);
    tick();
    idle();
    s_req = 2'b11;
    s_vppn = {19'h00100, 19'h00100}; s_va_bit12 = 2'b11; s_asid = {10'd6, 10'd5};
    tick();
    chk("4k_found", s_found, 2'b01);
    chk("4k_index", s_index[IDXW-1:0], 0);
    chk("4k_ppn_page1", s_ppn[19:0], 20'h1B);

    // 4M global entry into slot 1, page chosen by vppn[8]
    idle();
    we = 1; w_fill = 1; w_entry = mk(19'h00600, PS_4M, 10'd9, 1'b1, 20'h2A, 20'h2B);
    tick();
    idle();
    s_req = 2'b10; s_vppn[37:19] = 19'h00780; s_va_bit12[1] = 0; s_asid[19:10] = 10'h3FF;
    tick();
    chk("4m_found", s_found[1], 1'b1);
    chk("4m_index", s_index[2*IDXW-1:IDXW], 1);
    chk("4m_ppn_page1", s_ppn[39:20], 20'h2B);

    // Fill the free slots, then two more laps through rr_ptr
    idle();
    for (int k = 0; k < TLBNUM - 2; k++) begin
      chk("fill_free_idx", fill_index, k + 2);
      we = 1; w_fill = 1; w_entry = mk(19'(32'h1000 + k), PS_4K, 10'(k), 1'b0, 20'(k), 20'(k));
      tick();
    end
    for (int k = 0; k < TLBNUM + 3; k++) begin
      chk("fill_rr_idx", fill_index, k % TLBNUM);
      we = 1; w_fill = 1;
      w_entry = mk(19'(32'h2000 + k % TLBNUM), PS_4K, 10'(k % TLBNUM), 1'b0, 20'(k + 100), 20'(k + 200));
      tick();
    end
    idle();
    inv_valid = 1; inv_op = 5'd5; inv_asid = 10'd7; inv_vppn = 19'h02007;
    tick();
    idle();
    chk("inv5_fill_index", fill_index, 7);

    // Explicit write plus INVTLB op0 in one cycle; search sees old contents
    we = 1; w_fill = 0; w_index = 4'd3; w_entry = mk(19'h03333, PS_4K, 10'd1, 1'b1, 20'h33, 20'h34);
    inv_valid = 1; inv_op = 5'd0;
    s_req = 2'b01; s_vppn[18:0] = 19'h02005; s_va_bit12[0] = 0; s_asid[9:0] = 10'd5;
    tick();
    chk("same_cycle_old_found", s_found[0], 1'b1);
    chk("same_cycle_old_index", s_index[IDXW-1:0], 5);
    idle();
    s_req = 2'b11; s_vppn = {19'h02005, 19'h03333}; s_asid = {10'd5, 10'd0};
    tick();
    chk("inv0_write_survives", s_found, 2'b01);
    chk("inv0_write_index", s_index[IDXW-1:0], 3);
    chk("inv0_fill_index", fill_index, 0);

    // Illegal op pulses inv_err once
    idle();
    inv_valid = 1; inv_op = 5'd7;
    tick();
    chk("illegal_err_pulse", inv_err, 1'b1);
    idle();
    tick();
    chk("illegal_err_clear", inv_err, 1'b0);

    // Reset while results are valid
    s_req = 2'b11;
    tick();
    chk("pre_reset_rvalid", s_rvalid, 2'b11);
    reset = 1;
    #1;
    chk("async_reset_rvalid", s_rvalid, 2'b00);
    chk("async_reset_found", s_found, 2'b00);
    m_reset();
    #2;
    reset = 0;
    idle();

    // Randomized traffic on a small VA/ASID space so hits are common
    for (int c = 0; c < 3000; c++) begin
      s_req = NPORTS'($urandom);
      for (int p = 0; p < NPORTS; p++) begin
        s_vppn[p*19 +: 19] = rnd_vppn();
        s_va_bit12[p]      = 1'($urandom_range(0, 1));
        s_asid[p*10 +: 10] = 10'($urandom_range(0, 3));
      end
      we        = ($urandom_range(0, 2) == 0);
      w_fill    = 1'($urandom_range(0, 1));
      w_index   = IDXW'($urandom);
      w_entry   = rnd_entry();
      r_req     = 1'($urandom_range(0, 1));
      r_index   = IDXW'($urandom);
      inv_valid = ($urandom_range(0, 7) == 0);
      inv_op    = 5'($urandom_range(0, 8));
      inv_asid  = 10'($urandom_range(0, 3));
      inv_vppn  = rnd_vppn();
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
